// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ultrasonic ranger and its sensor/host side.
// The master side is the ranger itself; the slave side is the sensor and host.
interface ultrasonic_ranger_if;
    logic        enable_i;
    logic        echo_i;
    logic        trigger_o;
    logic [26:0] distance_o;
    logic        valid_o;
    logic        timeout_o;
    logic [11:0] stable_cnt_o;
    logic        stable_o;
    logic [2:0]  state_o;

    modport master (
        input  enable_i, echo_i,
        output trigger_o, distance_o, valid_o, timeout_o, stable_cnt_o, stable_o, state_o
    );

    modport slave (
        output enable_i, echo_i,
        input  trigger_o, distance_o, valid_o, timeout_o, stable_cnt_o, stable_o, state_o
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// Periodic trigger / echo-width ranger with timeout and stability tracking.
// Distances are echo widths in clk cycles; echo_i is synchronized before use.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3000000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int STABLE_TOL     = 1024,
    parameter int STABLE_TARGET  = 2048
) (
    input logic                 clk,
    input logic                 rst_n,
    ultrasonic_ranger_if.master bus
);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [26:0]   TOL         = 27'(STABLE_TOL);
    localparam logic [11:0]   TARGET      = 12'(STABLE_TARGET);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic          echo_meta, echo_s;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [26:0]   width_cnt, distance;
    logic [11:0]   stable_cnt, stable_cnt_nxt;
    logic          valid, timeout, stable, have_base;
    logic          meas_done, tmo_hit;

    function automatic logic [26:0] abs_diff(input logic [26:0] a, input logic [26:0] b);
        logic signed [27:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 27'(-d) : 27'(d);
    endfunction

    function automatic logic [26:0] sat_inc27(input logic [26:0] v);
        return (&v) ? v : v + 27'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction

    always_comb begin
        state_nxt      = state;
        meas_done      = 1'b0;
        tmo_hit        = 1'b0;
        stable_cnt_nxt = stable_cnt;
        if (!bus.enable_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:      state_nxt = TRIG;
                TRIG:      if (period_cnt == TRIG_LAST) state_nxt = WAIT_RISE;
                // Timeout wins over a late rise so the counter can never run past its limit.
                WAIT_RISE: begin
                    if (tmo_cnt == TMO_LAST) begin
                        tmo_hit   = 1'b1;
                        state_nxt = HOLD;
                    end else if (echo_s) begin
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        meas_done = 1'b1;
                        state_nxt = HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_hit   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD:      if (period_cnt >= PERIOD_LAST) state_nxt = TRIG;
                default:   state_nxt = IDLE;
            endcase
        end
        if (meas_done) begin
            if (!have_base)
                stable_cnt_nxt = 12'd0;
            else if (abs_diff(width_cnt, distance) <= TOL)
                stable_cnt_nxt = sat_inc12(stable_cnt);
            else
                stable_cnt_nxt = 12'd0;
        end else if (tmo_hit) begin
            stable_cnt_nxt = 12'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            echo_meta  <= 1'b0;
            echo_s     <= 1'b0;
            period_cnt <= '0;
            tmo_cnt    <= '0;
            width_cnt  <= '0;
            distance   <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            stable_cnt <= '0;
            stable     <= 1'b0;
            have_base  <= 1'b0;
        end else begin
            echo_meta  <= bus.echo_i;
            echo_s     <= echo_meta;
            state      <= state_nxt;
            valid      <= meas_done;
            timeout    <= tmo_hit;
            stable_cnt <= stable_cnt_nxt;
            stable     <= (stable_cnt_nxt >= TARGET);

            if (state_nxt == TRIG && state != TRIG)
                period_cnt <= '0;
            else if (state != IDLE)
                period_cnt <= period_cnt + 1'b1;

            if (state == TRIG && state_nxt == WAIT_RISE)
                tmo_cnt <= '0;
            else if (state == WAIT_RISE || state == MEASURE)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (state == WAIT_RISE && state_nxt == MEASURE)
                width_cnt <= 27'd1;
            else if (state == MEASURE && echo_s)
                width_cnt <= sat_inc27(width_cnt);

            if (meas_done)
                distance <= width_cnt;

            if (state == IDLE)
                have_base <= 1'b0;
            else if (meas_done)
                have_base <= 1'b1;
        end
    end

    assign bus.trigger_o    = (state == TRIG);
    assign bus.state_o      = state;
    assign bus.distance_o   = distance;
    assign bus.valid_o      = valid;
    assign bus.timeout_o    = timeout;
    assign bus.stable_cnt_o = stable_cnt;
    assign bus.stable_o     = stable;
endmodule
